fifo_frame_reader: RTL and testbench

Read-side client for the dual-clock FIFO: runs entirely in the FIFO read-clock domain, pops samples through the FIFO's `R_INC`/`R_DATA`/`R_EMPTY` port, and presents them as a valid/ready stream grouped into fixed-length frames with first/last markers. It sits between the clock-crossing FIFO and the FFT input stage, absorbing the FIFO's one-cycle read latency and the downstream back-pressure without dropping or duplicating samples.

---
 rtl/fifo_frame_reader.sv | 135 +++++++++++++
 tb/tb_fifo_frame_reader.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/fifo_frame_reader.sv
// fifo_frame_reader: read-side client of the dual-clock FIFO.
// Pops samples from the FIFO read port, hides the one-cycle read latency
// behind a 2-entry in-order buffer, and presents a valid/ready stream
// grouped into FRAME_LEN-sample frames with first/last markers.
module fifo_frame_reader #(
    parameter int DWL       = 16,
    parameter int FRAME_LEN = 256,
    parameter int CNT_W     = $clog2(FRAME_LEN)
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             i_EN,
    input  logic             FIFO_EMPTY,
    input  logic [DWL-1:0]   FIFO_DATA,
    output logic             FIFO_INC,
    output logic [DWL-1:0]   o_DATA,
    output logic             o_VALID,
    input  logic             i_READY,
    output logic             o_FIRST,
    output logic             o_LAST,
    output logic [CNT_W-1:0] o_IDX,
    output logic             o_FRAME_DONE
);

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_LEN - 1);

    typedef enum logic [1:0] {IDLE, RUN, STOP} state_t;

    state_t           state, state_nxt;
    logic [1:0]       occ;            // output buffer occupancy, 0..2
    logic             inflight;       // a pop was accepted last cycle
    logic [DWL-1:0]   head_q, tail_q; // in-order buffer, head is presented
    logic [CNT_W-1:0] issue_cnt, issue_cnt_nxt;
    logic [CNT_W-1:0] idx;
    logic             xfer;
    logic             issue_allowed;
    logic [2:0]       pending;        // samples committed after this cycle

    // State register
    always_ff @(posedge CLK) begin
        if (RST) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next state: a frame is only abandoned on its boundary; STOP keeps
    // issuing until the frame's pops are complete, then drains.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (i_EN) state_nxt = RUN;
            RUN:  if (!i_EN) state_nxt = (issue_cnt_nxt == '0) ? IDLE : STOP;
            STOP: begin
                if (i_EN)
                    state_nxt = RUN;
                else if (issue_cnt == '0 && occ == 2'd0 && !inflight)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs and pop request; i_READY is the only combinational path to FIFO_INC
    always_comb begin
        o_VALID       = (occ != 2'd0);
        xfer          = o_VALID && i_READY;
        issue_allowed = (state == RUN) || (state == STOP && issue_cnt != '0);
        pending       = {1'b0, occ} + {2'b00, inflight} - {2'b00, xfer};
        FIFO_INC      = issue_allowed && !FIFO_EMPTY && (pending < 3'd2);
        if (FIFO_INC)
            issue_cnt_nxt = (issue_cnt == LAST_IDX) ? '0 : issue_cnt + CNT_W'(1);
        else
            issue_cnt_nxt = issue_cnt;
        o_DATA  = head_q;
        o_IDX   = idx;
        o_FIRST = o_VALID && (idx == '0);
        o_LAST  = o_VALID && (idx == LAST_IDX);
    end

    // Pop bookkeeping: in-flight flag and per-frame issue counter
    always_ff @(posedge CLK) begin
        if (RST) begin
            inflight  <= 1'b0;
            issue_cnt <= '0;
        end else begin
            inflight  <= FIFO_INC;
            issue_cnt <= issue_cnt_nxt;
        end
    end

    // Buffer: capture returning FIFO data, retire the head on transfer
    always_ff @(posedge CLK) begin
        if (RST) begin
            occ    <= 2'd0;
            head_q <= '0;
            tail_q <= '0;
        end else begin
            case ({inflight, xfer})
                2'b01: begin
                    head_q <= tail_q;
                    occ    <= occ - 2'd1;
                end
                2'b10: begin
                    if (occ == 2'd0) head_q <= FIFO_DATA;
                    else             tail_q <= FIFO_DATA;
                    occ <= occ + 2'd1;
                end
                2'b11: begin
                    if (occ == 2'd1) begin
                        head_q <= FIFO_DATA;
                    end else begin
                        head_q <= tail_q;
                        tail_q <= FIFO_DATA;
                    end
                end
                default: ;
            endcase
        end
    end

    // Frame index of the head sample and end-of-frame pulse
    always_ff @(posedge CLK) begin
        if (RST) begin
            idx          <= '0;
            o_FRAME_DONE <= 1'b0;
        end else begin
            o_FRAME_DONE <= xfer && (idx == LAST_IDX);
            if (xfer) idx <= (idx == LAST_IDX) ? '0 : idx + CNT_W'(1);
        end
    end

    // Returning data must always find a free buffer slot
    a_no_overflow: assert property (@(posedge CLK) disable iff (RST)
        !(inflight && !xfer && occ == 2'd2));

endmodule

// File: tb/tb_fifo_frame_reader.sv
// Bench for fifo_frame_reader with FRAME_LEN=8: a queue-based FIFO model
// feeds the DUT; every transfer is checked against the order of popped
// words, frame position, markers and the frame-done pulse.
module tb_fifo_frame_reader;

    localparam int DWL = 16;
    localparam int FL  = 8;
    localparam int CW  = 3;

    logic           CLK = 1'b0;
    logic           RST = 1'b1;
    logic           i_EN = 1'b0;
    logic           FIFO_EMPTY = 1'b1;
    logic [DWL-1:0] FIFO_DATA = '0;
    logic           FIFO_INC;
    logic [DWL-1:0] o_DATA;
    logic           o_VALID;
    logic           i_READY = 1'b0;
    logic           o_FIRST;
    logic           o_LAST;
    logic [CW-1:0]  o_IDX;
    logic           o_FRAME_DONE;

    fifo_frame_reader #(.DWL(DWL), .FRAME_LEN(FL), .CNT_W(CW)) dut (
        .CLK(CLK), .RST(RST), .i_EN(i_EN), .FIFO_EMPTY(FIFO_EMPTY),
        .FIFO_DATA(FIFO_DATA), .FIFO_INC(FIFO_INC), .o_DATA(o_DATA),
        .o_VALID(o_VALID), .i_READY(i_READY), .o_FIRST(o_FIRST),
        .o_LAST(o_LAST), .o_IDX(o_IDX), .o_FRAME_DONE(o_FRAME_DONE)
    );

    always #5 CLK = ~CLK;

    int total = 0;
    int bad   = 0;

    logic [DWL-1:0] fq[$];    // FIFO contents
    logic [DWL-1:0] expq[$];  // popped, not yet transferred, in order
    int  next_val = 0;
    bit  pop_pending = 0, exp_done = 0, prev_hold = 0;
    logic [DWL-1:0] prev_data = '0;
    logic [CW-1:0]  prev_idx = '0;
    int  exp_idx = 0, cyc = 0;
    int  pops, xfers, dones, min_gap, max_gap, last_xfer, first_pop, first_xfer;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic clr();
        pops = 0; xfers = 0; dones = 0;
        min_gap = 1 << 30; max_gap = 0;
        last_xfer = -1; first_pop = -1; first_xfer = -1;
    endtask

    // One clock cycle: FIFO model update after the edge, then checks at negedge.
    task automatic step(input logic en, input logic rdy, input int npush);
        logic [DWL-1:0] v;
        int gap;
        @(posedge CLK); #1;
        if (pop_pending && fq.size() > 0) begin
            v = fq.pop_front();
            FIFO_DATA = v;
            expq.push_back(v);
        end
        pop_pending = 0;
        for (int k = 0; k < npush; k++) begin
            fq.push_back(DWL'(next_val));
            next_val++;
        end
        FIFO_EMPTY = (fq.size() == 0);
        i_EN = en;
        i_READY = rdy;
        @(negedge CLK);
        cyc++;
        chk("inc_while_empty", 32'(FIFO_INC && FIFO_EMPTY), 0);
        chk("frame_done", 32'(o_FRAME_DONE), 32'(exp_done));
        if (o_FRAME_DONE) dones++;
        exp_done = 0;
        chk("occ_le2", 32'(expq.size() <= 2), 1);
        if (prev_hold) begin
            chk("hold_valid", 32'(o_VALID), 1);
            chk("hold_data", 32'(o_DATA), 32'(prev_data));
            chk("hold_idx", 32'(o_IDX), 32'(prev_idx));
        end
        if (FIFO_INC) begin
            pop_pending = 1;
            pops++;
            if (first_pop < 0) first_pop = cyc;
        end
        if (o_VALID && i_READY) begin
            if (expq.size() == 0) chk("xfer_without_pop", 1, 0);
            else begin
                v = expq.pop_front();
                chk("data", 32'(o_DATA), 32'(v));
            end
            chk("idx", 32'(o_IDX), 32'(exp_idx));
            chk("first", 32'(o_FIRST), 32'(exp_idx == 0));
            chk("last", 32'(o_LAST), 32'(exp_idx == FL - 1));
            if (exp_idx == FL - 1) exp_done = 1;
            exp_idx = (exp_idx + 1) % FL;
            if (last_xfer >= 0) begin
                gap = cyc - last_xfer;
                if (gap < min_gap) min_gap = gap;
                if (gap > max_gap) max_gap = gap;
            end else begin
                first_xfer = cyc;
            end
            last_xfer = cyc;
            xfers++;
        end
        prev_hold = o_VALID && !i_READY;
        prev_data = o_DATA;
        prev_idx  = o_IDX;
    endtask

    // Synchronous reset pulse; the FIFO is reset alongside the block.
    task automatic do_reset();
        RST = 1'b1;
        i_EN = 1'b0;
        @(posedge CLK); #1;
        RST = 1'b0;
        fq.delete();
        expq.delete();
        pop_pending = 0; exp_done = 0; prev_hold = 0; exp_idx = 0;
        FIFO_EMPTY = 1'b1;
        @(negedge CLK);
        chk("rst_valid", 32'(o_VALID), 0);
        chk("rst_data", 32'(o_DATA), 0);
        chk("rst_idx", 32'(o_IDX), 0);
        chk("rst_first", 32'(o_FIRST), 0);
        chk("rst_last", 32'(o_LAST), 0);
        chk("rst_done", 32'(o_FRAME_DONE), 0);
        chk("rst_inc", 32'(FIFO_INC), 0);
    endtask

    initial begin
        int base, s;
        logic en_c;

        // Basic frame: 8 preloaded words, one-cycle enable pulse
        do_reset(); clr();
        step(1, 1, 8);
        repeat (20) step(0, 1, 0);
        chk("a_xfers", 32'(xfers), 8);
        chk("a_pops", 32'(pops), 8);
        chk("a_consecutive", 32'(max_gap), 1);
        chk("a_dones", 32'(dones), 1);
        step(0, 1, 4);
        repeat (5) step(0, 1, 0);
        chk("a_idle_no_pop", 32'(pops), 8);

        // Random back-pressure over 64 words
        do_reset(); clr();
        step(1, 1'($urandom_range(0, 1)), 64);
        for (int i = 0; i < 1000 && xfers < 64; i++) step(1, 1'($urandom_range(0, 1)), 0);
        repeat (4) step(1, 1, 0);
        chk("b_xfers", 32'(xfers), 64);
        chk("b_pops", 32'(pops), 64);
        chk("b_dones", 32'(dones), 8);
        chk("b_idx_wrapped", 32'(exp_idx), 0);

        // Enable drops after index 3 transfers: frame completes, nothing more popped
        do_reset(); clr();
        base = next_val;
        step(1, 1, 20);
        en_c = 1'b1;
        for (int i = 0; i < 40; i++) begin
            step(en_c, 1, 0);
            if (xfers >= 4) en_c = 1'b0;
        end
        chk("c_pops", 32'(pops), 8);
        chk("c_xfers", 32'(xfers), 8);
        chk("c_dones", 32'(dones), 1);
        chk("c_fifo_left", 32'(fq.size()), 12);
        if (fq.size() > 0) chk("c_fifo_head", 32'(fq[0]), 32'(DWL'(base + 8)));

        // Starved FIFO: one word every 5 cycles
        do_reset(); clr();
        for (int i = 0; i < 100; i++) step(1, 1, (i % 5 == 1) ? 1 : 0);
        chk("d_xfers", 32'(xfers), 20);
        chk("d_min_gap", 32'(min_gap), 5);
        chk("d_max_gap", 32'(max_gap), 5);
        chk("d_dones", 32'(dones), 2);

        // Reset with data buffered and in flight, then restart
        do_reset(); clr();
        step(1, 0, 10);
        repeat (3) step(1, 0, 0);
        step(1, 1, 0);
        do_reset(); clr();
        step(0, 1, 5);
        repeat (6) step(0, 1, 0);
        chk("e_no_pop_idle", 32'(pops), 0);
        chk("e_no_valid", 32'(o_VALID), 0);
        repeat (12) step(1, 1, 0);
        chk("e_pops", 32'(pops), 5);
        chk("e_xfers", 32'(xfers), 5);

        // Full throughput and start latency
        do_reset(); clr();
        step(1, 1, 64);
        s = cyc;
        repeat (70) step(1, 1, 0);
        chk("f_pop_latency", 32'(first_pop - s), 1);
        chk("f_valid_latency", 32'(first_xfer - first_pop), 2);
        chk("f_xfers", 32'(xfers), 64);
        chk("f_max_gap", 32'(max_gap), 1);
        chk("f_dones", 32'(dones), 8);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
